// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub, bit-serial unsigned multiply and divide.
// Optional divider is built only when SEQ_ALU_DIVIDER_EN is defined; otherwise opcode 5 is illegal.
`timescale 1ns/1ps
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       sig_alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             err,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_MULU = 5'd4;
`ifdef SEQ_ALU_DIVIDER_EN
    localparam logic [4:0] OP_DIVU = 5'd5;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef SEQ_ALU_DIVIDER_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    // Both sides transfer on valid & ready at a rising edge: a request is taken
    // only in IDLE, and a result stays frozen in DONE until out_ready is seen.
    logic accept;
    assign accept    = in_valid & in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

    logic [WIDTH-1:0] quick_res;
    logic [WIDTH-1:0] quick_hi;
    logic             quick_err;

    always_comb begin
        quick_res = '0;
        quick_hi  = '0;
        quick_err = 1'b0;
        case (sig_alu_control)
            OP_AND:  quick_res = src_a & src_b;
            OP_OR:   quick_res = src_a | src_b;
            OP_ADD:  quick_res = src_a + src_b;
            OP_SUB:  quick_res = src_a - src_b;
            OP_MULU: quick_res = '0;
`ifdef SEQ_ALU_DIVIDER_EN
            // Only reached for a zero divisor; non-zero divisors take the DIV path.
            OP_DIVU: begin
                quick_res = '1;
                quick_hi  = src_a;
                quick_err = 1'b1;
            end
`endif
            default: quick_err = 1'b1;
        endcase
    end

    // Shift-add step: {acc_hi, acc_lo} shifts right with the partial sum entering at the top.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIVIDER_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_q_next;

    always_comb begin
        div_shift    = {acc_hi, acc_lo[WIDTH-1]};
        div_diff     = div_shift - {1'b0, op_b};
        div_ge       = (div_shift >= {1'b0, op_b});
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_q_next   = {acc_lo[WIDTH-2:0], div_ge};
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            op_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_hi <= '0;
                        acc_lo <= src_a;
                        op_b   <= src_b;
                        cnt    <= '0;
                        if (sig_alu_control == OP_MULU) begin
                            state <= MUL;
                        end
`ifdef SEQ_ALU_DIVIDER_EN
                        else if (sig_alu_control == OP_DIVU && src_b != '0) begin
                            state <= DIV;
                        end
`endif
                        else begin
                            state     <= DONE;
                            result    <= quick_res;
                            result_hi <= quick_hi;
                            zero      <= (quick_res == '0);
                            err       <= quick_err;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_next;
                    acc_lo <= mul_lo_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        result    <= mul_lo_next;
                        result_hi <= mul_hi_next;
                        zero      <= (mul_lo_next == '0);
                        err       <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIVIDER_EN
                DIV: begin
                    acc_hi <= div_rem_next;
                    acc_lo <= div_q_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        result    <= div_q_next;
                        result_hi <= div_rem_next;
                        zero      <= (div_q_next == '0);
                        err       <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 src_a  input  WIDTH  operand A.
REQ-007 src_b  input  WIDTH  operand B.
REQ-008 sig_alu_control  input  5  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MULU, 5 DIVU; all others illegal.
REQ-009 out_valid  output  1  result registers hold a completed operation.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  WIDTH  primary result: logic/sum/difference, product low half, or quotient.
REQ-012 result_hi  output  WIDTH  product high half, or remainder; 0 for AND/OR/ADD/SUB.
REQ-013 zero  output  1  result == 0.
REQ-014 err  output  1  illegal opcode or divide-by-zero for the held result.

Function
REQ-015 FSM states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = in_valid & in_ready; operands and opcode SHALL be captured into internal registers at accept; inputs are don't-care afterwards.
REQ-017 AND/OR/ADD/SUB/illegal: IDLE->DONE at accept; out_valid asserted the cycle after accept (latency 1).
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH; carry/borrow discarded.
REQ-019 MULU: unsigned shift-add, one bit per cycle; IDLE->MUL, WIDTH cycles in MUL, then DONE; out_valid asserted WIDTH+1 cycles after accept; {result_hi,result} = full 2*WIDTH-bit product.
REQ-020 DIVU: unsigned restoring division, one bit per cycle; IDLE->DIV, WIDTH cycles, then DONE; latency WIDTH+1; result = quotient, result_hi = remainder.
REQ-021 DIVU with src_b==0: SHALL skip DIV, go to DONE with latency 1; result = all ones, result_hi = src_a, err=1.
REQ-022 Illegal opcode: result=0, result_hi=0, zero=1, err=1, latency 1.
REQ-023 DONE: out_valid=1; result, result_hi, zero, err SHALL hold stable until out_valid & out_ready, then DONE->IDLE.
REQ-024 No new request SHALL be accepted in the cycle a result is consumed; earliest next accept is the following cycle.
REQ-025 out_valid SHALL be 0 in IDLE, MUL, DIV; result outputs in those states retain the last completed values.
REQ-026 zero and err SHALL be registered alongside result, not derived combinationally from inputs.
REQ-027 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap during an operation.

Reset
REQ-028 reset_n low SHALL force state IDLE, out_valid=0, result=0, result_hi=0, zero=0, err=0, counter=0, in_ready=1 after deassertion, immediately and independent of clk.
REQ-029 reset_n asserted mid-MUL/DIV or in DONE SHALL abort the operation; partial results SHALL never appear on outputs.

Configuration
REQ-030 Macro SEQ_ALU_DIVIDER_EN: defined -> DIVU and DIV state implemented per REQ-020/021; undefined -> DIV state and divider datapath absent, opcode 5 handled as illegal per REQ-022.

Verification
REQ-031 WIDTH=32, ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid one cycle after accept, result=0, zero=1, err=0.
REQ-032 MULU 0xFFFFFFFF*0xFFFFFFFF -> out_valid at accept+33, result=0x00000001, result_hi=0xFFFFFFFE.
REQ-033 DIVU 100/7 with out_ready held 0 for 5 cycles after out_valid -> result=14, result_hi=2 stable throughout, in_ready=0 until cycle after handshake.
REQ-034 DIVU 0x1234/0 -> latency 1, result=0xFFFFFFFF, result_hi=0x1234, err=1; with macro undefined, opcode 5 -> result=0, err=1.
REQ-035 Opcode 9 -> result=0, zero=1, err=1; then reset_n pulsed low mid-MULU at cycle 10 -> out_valid=0, outputs 0, in_ready=1 after release, next SUB 5-7 returns 0xFFFFFFFE.
